// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer (0..99 s) with one-cycle timeout pulse.
// Optional run-time freeze via the pause input when COUNTDOWN_PAUSE_EN is defined.
module countdown_timer #(
    parameter int TICK_DIV = 100000000,
    parameter int PRESC_W  = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       start,
    input  logic       cancel,
    input  logic       pause,
    output logic [8:0] seconds,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    state_t             state_q, state_d;
    logic [7:0]         value_q, value_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [8:0]         seconds_q, seconds_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic               hold;
    logic [7:0]         value_dec;
    logic [7:0]         value_clamped;

`ifdef COUNTDOWN_PAUSE_EN
    assign hold = pause;
`else
    logic pause_unused;
    assign pause_unused = pause;
    assign hold = 1'b0;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign value_clamped = {clamp_digit(load_value[7:4]), clamp_digit(load_value[3:0])};

    // BCD decrement; only ever applied to a nonzero value
    always_comb begin
        value_dec = value_q;
        if (value_q[3:0] != 4'd0) begin
            value_dec[3:0] = value_q[3:0] - 4'd1;
        end else begin
            value_dec[3:0] = 4'd9;
            value_dec[7:4] = value_q[7:4] - 4'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            value_q   <= 8'h00;
            presc_q   <= '0;
            seconds_q <= 9'h000;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            presc_q   <= presc_d;
            seconds_q <= seconds_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and datapath update; cancel > load > start
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        presc_d   = presc_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cancel) begin
                    value_d = 8'h00;
                end else if (load) begin
                    value_d = value_clamped;
                end else if (start) begin
                    presc_d = '0;
                    if (value_q != 8'h00) begin
                        state_d = RUN;
                    end else begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                    value_d = 8'h00;
                    presc_d = '0;
                end else if (!hold) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        value_d = value_dec;
                        if (value_dec == 8'h00) begin
                            state_d   = DONE;
                            timeout_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (cancel) begin
                    state_d = IDLE;
                    value_d = 8'h00;
                end else if (load) begin
                    state_d = IDLE;
                    value_d = value_clamped;
                end
            end
            default: begin
                state_d = IDLE;
                value_d = 8'h00;
                presc_d = '0;
            end
        endcase
    end

    // Outputs registered from next-state so they line up with value_q/state_q
    always_comb begin
        seconds_d = {state_d != IDLE, value_d};
        busy_d    = (state_d == RUN);
    end

    assign seconds = seconds_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       pause = 1'b0;
    logic [8:0] seconds;
    logic       timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.TICK_DIV(4), .PRESC_W(3)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .cancel(cancel), .pause(pause),
        .seconds(seconds), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_value = v; load = 1'b1; tick(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if (seconds !== 9'h000 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: seconds=%h timeout=%b busy=%b, want 000/0/0", seconds, timeout, busy);
        end
        tick();
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_countdown();
        logic [7:0] seq [12];
        logic [7:0] prev;
        logic [8:0] es;
        logic       et;
        seq = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        do_load(8'h12);
        checks++;
        if (seconds !== 9'h012 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_12: seconds=%h busy=%b, want 012/0", seconds, busy);
        end
        do_start();
        checks++;
        if (seconds !== 9'h112 || busy !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL start_12: seconds=%h busy=%b timeout=%b, want 112/1/0", seconds, busy, timeout);
        end
        prev = 8'h12;
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                es = {1'b1, (c < 3) ? prev : seq[i]};
                et = (c == 3) && (seq[i] == 8'h00);
                checks++;
                if (seconds !== es || timeout !== et || busy !== !et) begin
                    errors++;
                    $display("FAIL countdown[%0d.%0d]: seconds=%h timeout=%b busy=%b, want %h/%b/%b",
                             i, c, seconds, timeout, busy, es, et, !et);
                end
            end
            prev = seq[i];
        end
        tick();
        checks++;
        if (seconds !== 9'h100 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: seconds=%h timeout=%b busy=%b, want 100/0/0", seconds, timeout, busy);
        end
        do_start();
        tick();
        checks++;
        if (seconds !== 9'h100 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_start_ignored: seconds=%h timeout=%b busy=%b, want 100/0/0", seconds, timeout, busy);
        end
    endtask

    task automatic test_sanitise();
        do_load(8'hA7);
        checks++;
        if (seconds !== 9'h097) begin
            errors++;
            $display("FAIL load_A7: seconds=%h, want 097", seconds);
        end
        do_load(8'hFF);
        checks++;
        if (seconds !== 9'h099) begin
            errors++;
            $display("FAIL load_FF: seconds=%h, want 099", seconds);
        end
        do_load(8'h3C);
        checks++;
        if (seconds !== 9'h039) begin
            errors++;
            $display("FAIL load_3C: seconds=%h, want 039", seconds);
        end
    endtask

    task automatic test_cancel();
        do_load(8'h05);
        do_start();
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (timeout !== 1'b0 || busy !== 1'b1 || seconds !== ((c < 3) ? 9'h105 : 9'h104)) begin
                errors++;
                $display("FAIL run_05[%0d]: seconds=%h timeout=%b busy=%b", c, seconds, timeout, busy);
            end
        end
        do_cancel();
        checks++;
        if (seconds !== 9'h000 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_run: seconds=%h timeout=%b busy=%b, want 000/0/0", seconds, timeout, busy);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (timeout !== 1'b0 || seconds !== 9'h000) begin
                errors++;
                $display("FAIL after_cancel[%0d]: seconds=%h timeout=%b, want 000/0", c, seconds, timeout);
            end
        end
        do_load(8'h03);
        do_start();
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c % 4 == 0) begin
                checks++;
                if (seconds !== {1'b1, 8'(3 - c / 4)} || timeout !== (c == 12)) begin
                    errors++;
                    $display("FAIL run_03[%0d]: seconds=%h timeout=%b", c, seconds, timeout);
                end
            end
        end
        do_cancel();
        checks++;
        if (seconds !== 9'h000 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL cancel_done: seconds=%h busy=%b timeout=%b, want 000/0/0", seconds, busy, timeout);
        end
    endtask

    task automatic test_zero_start();
        do_start();
        checks++;
        if (seconds !== 9'h100 || timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_start: seconds=%h timeout=%b busy=%b, want 100/1/0", seconds, timeout, busy);
        end
        tick();
        checks++;
        if (seconds !== 9'h100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL zero_single_pulse: seconds=%h timeout=%b, want 100/0", seconds, timeout);
        end
        do_load(8'h20);
        checks++;
        if (seconds !== 9'h020 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_20_from_done: seconds=%h busy=%b, want 020/0", seconds, busy);
        end
    endtask

    task automatic test_priority();
        load_value = 8'h45; load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (seconds !== 9'h045 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_start: seconds=%h busy=%b, want 045/0", seconds, busy);
        end
        cancel = 1'b1; start = 1'b1;
        tick();
        cancel = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (seconds[8] !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL cancel_start: flag=%b busy=%b timeout=%b, want 0/0/0", seconds[8], busy, timeout);
        end
        do_load(8'h03);
        do_start();
        do_load(8'h09);
        do_start();
        checks++;
        if (seconds !== 9'h103 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_ignores_load: seconds=%h busy=%b, want 103/1", seconds, busy);
        end
        do_cancel();
    endtask

    task automatic test_pause();
        do_load(8'h02);
        do_start();
        tick(); tick();
        pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
`ifdef COUNTDOWN_PAUSE_EN
            checks++;
            if (seconds !== 9'h102 || busy !== 1'b1) begin
                errors++;
                $display("FAIL paused[%0d]: seconds=%h busy=%b, want 102/1", c, seconds, busy);
            end
`else
            if (c == 1) begin
                checks++;
                if (seconds !== 9'h101) begin
                    errors++;
                    $display("FAIL pause_ignored: seconds=%h, want 101", seconds);
                end
            end
`endif
        end
        pause = 1'b0;
`ifdef COUNTDOWN_PAUSE_EN
        tick();
        checks++;
        if (seconds !== 9'h102) begin
            errors++;
            $display("FAIL resume_1: seconds=%h, want 102", seconds);
        end
        tick();
        checks++;
        if (seconds !== 9'h101) begin
            errors++;
            $display("FAIL resume_2: seconds=%h, want 101", seconds);
        end
        pause = 1'b1;
        tick();
        do_cancel();
        pause = 1'b0;
        checks++;
        if (seconds !== 9'h000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_paused: seconds=%h busy=%b, want 000/0", seconds, busy);
        end
`else
        do_cancel();
`endif
    endtask

    task automatic test_reset_mid_run();
        do_load(8'h07);
        do_start();
        tick(); tick();
        checks++;
        if (seconds !== 9'h107 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: seconds=%h busy=%b, want 107/1", seconds, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (seconds !== 9'h000 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: seconds=%h busy=%b timeout=%b, want 000/0/0", seconds, busy, timeout);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        #2 reset = 1'b0;
        tick();
        checks++;
        if (seconds !== 9'h000 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL start_in_reset: seconds=%h busy=%b timeout=%b, want 000/0/0", seconds, busy, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_sanitise();
        test_cancel();
        test_zero_start();
        test_priority();
        test_pause();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
